adc_capture_pio: RTL
====================

Name: adc_capture_pio

Overview:
- Parametrised successor to the single-register ADC input PIO.
- Captures ADC samples qualified by a valid strobe into an internal FIFO, so the Nios/Avalon-MM master no longer polls a live port and misses samples.
- Adds capture enable, flush, sticky overrun, FIFO level status and an optional level-threshold interrupt.
- Sits between the ADC front-end logic and the Avalon-MM interconnect, on the same clock as the bus.

Parameters:
- DATA_WIDTH, 16: ADC sample width, 1..32.
- FIFO_DEPTH, 16: sample buffer depth; power of two, 2..1024.
- SIGN_EXT, 0: 1 sign-extends samples to 32 bits on readdata; 0 zero-extends.

Ports:
- clk  in  1  system/bus clock
- reset_n  in  1  asynchronous active-low reset
- chipselect  in  1  Avalon-MM slave select
- address  in  2  register select
- read  in  1  read strobe, qualified by chipselect
- write  in  1  write strobe, qualified by chipselect
- writedata  in  32  write data
- readdata  out  32  registered read data
- in_port  in  DATA_WIDTH  ADC sample
- in_valid  in  1  sample strobe, one cycle per sample
- irq  out  1  level interrupt, active high

Behaviour:
- Reset:
  - readdata=0, irq=0.
  - FIFO empty, level=0.
  - CONTROL=0, THRESHOLD=0, overrun=0.
- Register map:
  - 0 DATA (RO, pop on read).
  - 1 STATUS (RO): bit0 empty, bit1 full, bit2 overrun, bit3 irq_pending, bits[26:16] level.
  - 2 CONTROL (RW): bit0 capture_en, bit1 flush (self-clearing, reads 0), bit2 irq_en.
  - 3 THRESHOLD (RW): bits[10:0]; unused bits read 0.
- Read timing: fixed latency 1. readdata is updated on the clock edge after chipselect&read and held until the next read.
- Writes take effect on the clock edge where chipselect&write is high. Writes to addresses 0 and 1 are ignored.
- Push: in_valid & capture_en & ~flush writes in_port at the tail.
- Pop: chipselect & read & address==0 & ~empty.
  - readdata gets the head sample, extended per SIGN_EXT.
  - Read of DATA while empty: readdata=0, no pointer change, no error.
- Simultaneous push and pop:
  - Both occur and level is unchanged.
  - This holds when full: no overrun, and the new sample is stored.
- Push when full without a pop: sample dropped, overrun set (sticky).
- Flush (write CONTROL with bit1=1):
  - Pointers and level go to 0 and overrun clears in that cycle.
  - A push or pop in the same cycle is discarded.
  - capture_en and irq_en take the written values.
- Pointers wrap modulo FIFO_DEPTH. Level ranges 0..FIFO_DEPTH, with full when level==FIFO_DEPTH.
- STATUS reflects state before any same-cycle update.
- Storage: inferred RAM with registered read is allowed only if DATA read latency stays 1. Otherwise use a register array.

Optional Feature:
- Macro: ADC_CAPTURE_PIO_IRQ_EN.
- Defined:
  - irq_pending = irq_en & ((THRESHOLD!=0 & level>=THRESHOLD) | overrun).
  - irq is irq_pending registered, so it asserts 1 cycle after the condition.
  - irq clears when the condition clears: drain below threshold, flush, or irq_en=0.
- Undefined:
  - irq tied 0.
  - THRESHOLD and CONTROL bit2 read 0 and ignore writes; STATUS bit3 reads 0.

Decomposition:
- Package adc_capture_pio_pkg holds:
  - register address constants ADDR_DATA/STATUS/CONTROL/THRESHOLD;
  - STATUS and CONTROL bit indices;
  - LEVEL_LSB=16;
  - a clog2 function.
- Sub-module adc_capture_fifo: synchronous FIFO with push, pop, flush, level, empty and full, parametrised by DATA_WIDTH and FIFO_DEPTH.
- The top level holds the Avalon decode, registers, extension and irq.

Test Plan:
- Reset, then read all 4 addresses -> DATA=0, STATUS=0x00000001, CONTROL=0, THRESHOLD=0; irq=0.
- capture_en=1, push 0x1234, 0x8001 (SIGN_EXT=1) -> STATUS level=2; DATA reads 0x00001234, then 0xFFFF8001; then STATUS=0x00000001.
- Push 17 samples with DEPTH=16, no reads -> STATUS=0x00100006 (level 16, full, overrun); the first 16 samples read back in order and the 17th is absent.
- Full FIFO, in_valid coincident with a DATA read -> level stays 16, overrun stays 0, last sample read is the new one.
- THRESHOLD=4, irq_en=1 (macro defined) -> irq rises 1 cycle after the 4th push and falls 1 cycle after the pop to level 3. Flush at level 8 clears irq and overrun.
- Assert reset_n low mid-burst with level=5 -> all outputs are 0 immediately (asynchronously); after release, STATUS=0x00000001 and captures restart only after capture_en is written.

Source files
------------

// File: rtl/adc_capture_pio_pkg.sv
// rtl/adc_capture_pio_pkg.sv - register map, bit indices and helpers for adc_capture_pio
// Shared by adc_capture_fifo and adc_capture_pio. No ports.

package adc_capture_pio_pkg;

   // Avalon-MM register addresses
   localparam logic [1:0] ADDR_DATA      = 2'd0;
   localparam logic [1:0] ADDR_STATUS    = 2'd1;
   localparam logic [1:0] ADDR_CONTROL   = 2'd2;
   localparam logic [1:0] ADDR_THRESHOLD = 2'd3;

   // STATUS bit positions
   localparam int STATUS_EMPTY   = 0;
   localparam int STATUS_FULL    = 1;
   localparam int STATUS_OVERRUN = 2;
   localparam int STATUS_IRQ     = 3;
   localparam int LEVEL_LSB      = 16;
   localparam int LEVEL_WIDTH    = 11;

   // CONTROL bit positions
   localparam int CTRL_CAPTURE_EN = 0;
   localparam int CTRL_FLUSH      = 1;
   localparam int CTRL_IRQ_EN     = 2;

   localparam int THRESHOLD_WIDTH = 11;

   // Ceiling log2, usable in parameter expressions
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/adc_capture_fifo.sv
// rtl/adc_capture_fifo.sv - synchronous sample FIFO with flush and level count
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   flush               clears pointers and level; discards same-cycle push/pop
//   push, push_data     write request and sample
//   pop                 read request (ignored while empty)
//   pop_data            head sample, combinational from the register array
//   level, empty, full  occupancy, 0..FIFO_DEPTH

module adc_capture_fifo
   import adc_capture_pio_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int FIFO_DEPTH = 16,
   localparam int AW = clog2(FIFO_DEPTH),
   localparam int LW = AW + 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  flush,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] pop_data,
   output logic [LW-1:0]         level,
   output logic                  empty,
   output logic                  full
);

   logic [DATA_WIDTH-1:0] mem [0:FIFO_DEPTH-1];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic                  do_push;
   logic                  do_pop;

   assign empty = (level == '0);
   assign full  = (level == LW'(FIFO_DEPTH));

   // A pop frees the slot the same cycle, so a full FIFO still accepts a
   // push when it is being read.
   assign do_pop  = pop & ~empty & ~flush;
   assign do_push = push & ~flush & (~full | do_pop);

   // Head is read straight from the array so DATA keeps a one-cycle latency
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers are AW bits wide, so they wrap modulo FIFO_DEPTH for free
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/adc_capture_pio.sv
// rtl/adc_capture_pio.sv - buffered ADC sample capture with Avalon-MM register interface
// Optional threshold/overrun interrupt enabled by defining ADC_CAPTURE_PIO_IRQ_EN.
// Ports:
//   clk, reset_n          bus clock, asynchronous active-low reset
//   chipselect, address   Avalon-MM slave select and register address
//   read, write           strobes, qualified by chipselect
//   writedata, readdata   32-bit write data, registered read data (latency 1)
//   in_port, in_valid     ADC sample and its one-cycle strobe
//   irq                   level interrupt, active high

module adc_capture_pio
   import adc_capture_pio_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int FIFO_DEPTH = 16,
   parameter int SIGN_EXT   = 0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  chipselect,
   input  logic [1:0]            address,
   input  logic                  read,
   input  logic                  write,
   input  logic [31:0]           writedata,
   output logic [31:0]           readdata,
   input  logic [DATA_WIDTH-1:0] in_port,
   input  logic                  in_valid,
   output logic                  irq
);

   localparam int LW = clog2(FIFO_DEPTH) + 1;

   logic                       rd_en;
   logic                       wr_en;
   logic                       ctrl_wr;
   logic                       flush;
   logic                       push_req;
   logic                       pop_req;
   logic                       capture_en;
   logic                       overrun;
   logic                       irq_en;
   logic                       irq_pending;
   logic [THRESHOLD_WIDTH-1:0] threshold;
   logic [DATA_WIDTH-1:0]      fifo_head;
   logic [LW-1:0]              fifo_level;
   logic                       fifo_empty;
   logic                       fifo_full;
   logic [LEVEL_WIDTH-1:0]     level_ext;
   logic [31:0]                head_ext;
   logic [31:0]                rd_mux;
   logic                       unused_wdata;

   assign rd_en    = chipselect & read;
   assign wr_en    = chipselect & write;
   assign ctrl_wr  = wr_en & (address == ADDR_CONTROL);
   assign flush    = ctrl_wr & writedata[CTRL_FLUSH];
   assign push_req = in_valid & capture_en;
   assign pop_req  = rd_en & (address == ADDR_DATA);

   assign level_ext = LEVEL_WIDTH'(fifo_level);

   adc_capture_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (flush),
      .push      (push_req),
      .push_data (in_port),
      .pop       (pop_req),
      .pop_data  (fifo_head),
      .level     (fifo_level),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   // Widen the head sample to the 32-bit bus
   generate
      if (DATA_WIDTH == 32) begin : g_no_ext
         assign head_ext = fifo_head;
      end else begin : g_ext
         logic fill;
         assign fill     = (SIGN_EXT != 0) ? fifo_head[DATA_WIDTH-1] : 1'b0;
         assign head_ext = {{(32-DATA_WIDTH){fill}}, fifo_head};
      end
   endgenerate

`ifdef ADC_CAPTURE_PIO_IRQ_EN
   assign irq_pending = irq_en &
                        (((threshold != '0) && (level_ext >= threshold)) | overrun);
   assign unused_wdata = ^writedata[31:THRESHOLD_WIDTH];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_en    <= 1'b0;
         threshold <= '0;
         irq       <= 1'b0;
      end else begin
         if (ctrl_wr) begin
            irq_en <= writedata[CTRL_IRQ_EN];
         end
         if (wr_en && (address == ADDR_THRESHOLD)) begin
            threshold <= writedata[THRESHOLD_WIDTH-1:0];
         end
         irq <= irq_pending;
      end
   end
`else
   assign irq_en       = 1'b0;
   assign threshold    = '0;
   assign irq_pending  = 1'b0;
   assign irq          = 1'b0;
   assign unused_wdata = ^{writedata[31:3], writedata[CTRL_IRQ_EN]};
`endif

   // Register read mux; STATUS shows the state before this cycle's update
   always_comb begin
      rd_mux = '0;
      case (address)
         ADDR_DATA: begin
            rd_mux = fifo_empty ? 32'd0 : head_ext;
         end
         ADDR_STATUS: begin
            rd_mux[STATUS_EMPTY]                    = fifo_empty;
            rd_mux[STATUS_FULL]                     = fifo_full;
            rd_mux[STATUS_OVERRUN]                  = overrun;
            rd_mux[STATUS_IRQ]                      = irq_pending;
            rd_mux[LEVEL_LSB +: LEVEL_WIDTH]        = level_ext;
         end
         ADDR_CONTROL: begin
            rd_mux[CTRL_CAPTURE_EN] = capture_en;
            rd_mux[CTRL_IRQ_EN]     = irq_en;
         end
         ADDR_THRESHOLD: begin
            rd_mux[THRESHOLD_WIDTH-1:0] = threshold;
         end
         default: begin
            rd_mux = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         capture_en <= 1'b0;
         overrun    <= 1'b0;
         readdata   <= '0;
      end else begin
         if (ctrl_wr) begin
            capture_en <= writedata[CTRL_CAPTURE_EN];
         end
         // A pop while full makes room, so only an unaccompanied push overflows
         if (flush) begin
            overrun <= 1'b0;
         end else if (push_req && fifo_full && !pop_req) begin
            overrun <= 1'b1;
         end
         if (rd_en) begin
            readdata <= rd_mux;
         end
      end
   end

endmodule
